// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared types and constants for the datapath sequencer.
// Holds the 3-bit state encoding, the control-word struct/constants and ITER_W.
package seq_ctrl_pkg;

    localparam int ITER_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD_A = 3'd1,
        S_LD_B = 3'd2,
        S_ADD  = 3'd3,
        S_ACC  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    typedef struct packed {
        logic       clr;
        logic [1:0] sel;
        logic [2:0] w;
        logic [2:0] s;
        logic [3:0] ce;
    } ctrl_t;

    localparam ctrl_t CW_IDLE = '{clr: 1'b1, sel: 2'd0, w: 3'd0, s: 3'd0, ce: 4'd0};
    localparam ctrl_t CW_LD_A = '{clr: 1'b0, sel: 2'd0, w: 3'd0, s: 3'd2, ce: 4'd1};
    localparam ctrl_t CW_LD_B = '{clr: 1'b0, sel: 2'd0, w: 3'd0, s: 3'd2, ce: 4'd8};
    localparam ctrl_t CW_ADD  = '{clr: 1'b0, sel: 2'd1, w: 3'd0, s: 3'd1, ce: 4'd2};
    localparam ctrl_t CW_ACC  = '{clr: 1'b0, sel: 2'd1, w: 3'd0, s: 3'd1, ce: 4'd8};
    localparam ctrl_t CW_WR   = '{clr: 1'b0, sel: 2'd1, w: 3'd4, s: 3'd1, ce: 4'd4};
    localparam ctrl_t CW_DONE = '{clr: 1'b0, sel: 2'd1, w: 3'd4, s: 3'd1, ce: 4'd0};

endpackage

// File: rtl/seq_ctrl_decode.sv
// seq_ctrl_decode: Moore decode of the sequencer state into the control word.
// Ports: state (in), ctrl {clr,sel,w,s,ce} (out). Unused encodings give CW_IDLE.
module seq_ctrl_decode
    import seq_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = CW_IDLE;
        case (state)
            S_IDLE:  ctrl = CW_IDLE;
            S_LD_A:  ctrl = CW_LD_A;
            S_LD_B:  ctrl = CW_LD_B;
            S_ADD:   ctrl = CW_ADD;
            S_ACC:   ctrl = CW_ACC;
            S_WR:    ctrl = CW_WR;
            S_DONE:  ctrl = CW_DONE;
            default: ctrl = CW_IDLE;
        endcase
    end

endmodule

// File: rtl/dp_seq_ctrl.sv
// dp_seq_ctrl: load/add/accumulate/write sequencer looping iter times per start.
// Ports: clk, rst (async high), start, iter[3:0], abort (only with SEQ_ABORT_EN),
// busy, done, clr, sel[1:0], w[2:0], s[2:0], ce[3:0]. Optional macro: SEQ_ABORT_EN.
module dp_seq_ctrl
    import seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] iter,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              clr,
    output logic [1:0]        sel,
    output logic [2:0]        w,
    output logic [2:0]        s,
    output logic [3:0]        ce
);

    state_t            state;
    state_t            nxt;
    logic [ITER_W-1:0] cnt;
    logic [ITER_W-1:0] cnt_nxt;
    ctrl_t             cw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt     = S_LD_A;
                    cnt_nxt = iter;
                end
            end
            S_LD_A: nxt = S_LD_B;
            S_LD_B: nxt = (cnt == '0) ? S_DONE : S_ADD;
            S_ADD:  nxt = S_ACC;
            S_ACC:  nxt = S_WR;
            S_WR: begin
                nxt = (cnt == ITER_W'(1)) ? S_DONE : S_ADD;
                // Saturate at zero so the count can never wrap.
                if (cnt != '0) begin
                    cnt_nxt = cnt - ITER_W'(1);
                end
            end
            S_DONE: nxt = S_IDLE;
            default: begin
                nxt     = S_IDLE;
                cnt_nxt = '0;
            end
        endcase
`ifdef SEQ_ABORT_EN
        // Abort wins over everything, including a start seen in IDLE.
        if (abort) begin
            nxt     = S_IDLE;
            cnt_nxt = '0;
        end
`endif
    end

    seq_ctrl_decode u_dec (
        .state (state),
        .ctrl  (cw)
    );

    assign clr  = cw.clr;
    assign sel  = cw.sel;
    assign w    = cw.w;
    assign s    = cw.s;
    assign ce   = cw.ce;
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
